// File: rtl/pyrm_wb_pkg.sv
// Shared types for the register-file write-back arbiter and its queue.
package pyrm_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WB_DATA_W = 64;

    // One queued register write: destination index plus value.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Identifies a requester; also the encoding of the round-robin pointer.
    typedef enum logic {
        WB_REQ_MEM = 1'b0,
        WB_REQ_ALU = 1'b1
    } wb_req_e;

endpackage

// File: rtl/pyrm_wb_fifo.sv
// In-order queue of granted write-backs. Pointers carry one extra wrap bit
// so full and empty are told apart by comparing the MSBs.
module pyrm_wb_fifo
    import pyrm_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Status flags from registered pointers; requests gated so the queue never over/underflows.
    always_comb begin
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty   = (wr_ptr == rd_ptr);
        count   = wr_ptr - rd_ptr;
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr[AW-1:0]];
    end

    // Pointer advance; reset drops every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/pyrm_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between the ALU
// and load-return paths, drops x0 writes, and queues the rest in order.
//
// Handshake on every stream: a transfer happens on a cycle where valid=1 and
// retry=0. A sender that sees retry=1 holds its fields and valid unchanged
// into the next cycle.
module pyrm_wb_arbiter
    import pyrm_wb_pkg::*;
#(
    parameter int DATA_W     = 64,   // must not exceed WB_DATA_W
    parameter int FIFO_DEPTH = 2,    // power of two, at least 2
    parameter bit RR_EN      = 1'b1  // 0: MEM always wins contention
) (
    input  logic                 clk,
    input  logic                 reset_pyri,
    input  logic [REG_IDX_W-1:0] alu_dest_pyri,
    input  logic [DATA_W-1:0]    alu_data_pyri,
    input  logic                 alu_valid_pyri,
    output logic                 alu_retry_pyro,
    input  logic [REG_IDX_W-1:0] mem_dest_pyri,
    input  logic [DATA_W-1:0]    mem_data_pyri,
    input  logic                 mem_valid_pyri,
    output logic                 mem_retry_pyro,
    output logic [DATA_W-1:0]    reg_addr_pyro,
    output logic                 reg_addr_valid_pyro,
    input  logic                 reg_addr_retry_pyri,
    output logic [DATA_W-1:0]    reg_data_pyro,
    output logic                 reg_data_valid_pyro,
    input  logic                 reg_data_retry_pyri
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_e          rr_ptr;
    wb_req_e          rr_ptr_next;
    logic             space;
    logic             contended;
    logic             grant_mem;
    logic             grant_alu;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Room is judged from registered occupancy only, so decode stalls never
    // reach the producer retries combinationally; reset holds both off.
    assign space = reset_pyri && (fifo_count < CNT_W'(FIFO_DEPTH));

    // Pointer register: after reset MEM has first claim on a contended cycle.
    always_ff @(posedge clk or negedge reset_pyri) begin
        if (!reset_pyri) rr_ptr <= WB_REQ_MEM;
        else             rr_ptr <= rr_ptr_next;
    end

    // Next pointer: only a contended grant hands priority to the other side.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (contended) begin
            if (grant_mem) rr_ptr_next = WB_REQ_ALU;
            else           rr_ptr_next = WB_REQ_MEM;
        end
    end

    // Grant, retry and queue-push decode for the current cycle.
    always_comb begin
        grant_mem  = 1'b0;
        grant_alu  = 1'b0;
        push_entry = '0;
        contended  = space && mem_valid_pyri && alu_valid_pyri;
        if (contended) begin
            if (RR_EN && (rr_ptr == WB_REQ_ALU)) grant_alu = 1'b1;
            else                                 grant_mem = 1'b1;
        end else if (space) begin
            grant_mem = mem_valid_pyri;
            grant_alu = alu_valid_pyri;
        end
        mem_retry_pyro = !space || (mem_valid_pyri && !grant_mem);
        alu_retry_pyro = !space || (alu_valid_pyri && !grant_alu);
        if (grant_mem) begin
            push_entry.dest = mem_dest_pyri;
            push_entry.data = WB_DATA_W'(mem_data_pyri);
        end else if (grant_alu) begin
            push_entry.dest = alu_dest_pyri;
            push_entry.data = WB_DATA_W'(alu_data_pyri);
        end
        // x0 writes complete their handshake but never enter the queue.
        fifo_push = (grant_mem || grant_alu) && (push_entry.dest != '0) && !fifo_full;
    end

    pyrm_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_pyri),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Both decode streams move together; either retry stalls the pair.
    assign fifo_pop            = !fifo_empty && !reg_addr_retry_pyri && !reg_data_retry_pyri;
    assign reg_addr_valid_pyro = !fifo_empty;
    assign reg_data_valid_pyro = !fifo_empty;
    assign reg_addr_pyro       = fifo_empty ? '0 : DATA_W'(head.dest);
    assign reg_data_pyro       = fifo_empty ? '0 : DATA_W'(head.data);

endmodule
